// File: rtl/isa_mem_pkg.sv
// Shared widths and loader state encoding for the instruction memory and fetch stage.
package isa_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Program-load byte stream and fetch read port bundled as one interface.
interface instr_mem_loader_if
  import isa_mem_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
);

  logic          load_start;
  logic [AW:0]   load_len;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          load_busy;
  logic          load_done;
  logic          load_error;
  logic          fetch_en;
  logic [AW-1:0] fetch_addr;
  logic [DW-1:0] fetch_instr;
  logic          fetch_valid;

  modport master (
    output load_start, load_len, byte_in, byte_valid, fetch_en, fetch_addr,
    input  byte_ready, load_busy, load_done, load_error, fetch_instr, fetch_valid
  );

  modport slave (
    input  load_start, load_len, byte_in, byte_valid, fetch_en, fetch_addr,
    output byte_ready, load_busy, load_done, load_error, fetch_instr, fetch_valid
  );

endinterface

// File: rtl/instr_ram.sv
// Single-clock instruction RAM: synchronous write, registered read with hold.
module instr_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Write port: contents survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; output register holds when no read is issued.
  always_ff @(posedge clk) begin
    if (rst)     rd_data_q <= '0;
    else if (re) rd_data_q <= mem[raddr];
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Program loader FSM: packs a byte stream little-endian into words, writes them
// from address 0 upward, and serves one-cycle-latency fetch reads while idle.
module instr_mem_loader #(
  parameter int ADDR_W = isa_mem_pkg::ADDR_W,
  parameter int DATA_W = isa_mem_pkg::DATA_W,
  parameter int DEPTH  = isa_mem_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  instr_mem_loader_if.slave        bus
);

  import isa_mem_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              load_error_q, load_error_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              hs;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] wr_word;

  // Next-state, counter and byte-assembly decode.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    wr_addr_d     = wr_addr_q;
    byte_cnt_d    = byte_cnt_q;
    asm_d         = asm_q;
    load_error_d  = 1'b0;
    hs            = (state_q == ST_LOAD) && bus.byte_valid;
    wr_en         = hs && (byte_cnt_q == 2'd3);
    // The fourth byte completes the word straight from the input, so only
    // three bytes ever need to be held.
    wr_word       = DATA_W'({bus.byte_in, asm_q});
    rd_en         = bus.fetch_en && (state_q == ST_IDLE);
    fetch_valid_d = rd_en;

    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          if ((bus.load_len == '0) || (bus.load_len > DEPTH_L)) begin
            load_error_d = 1'b1;
          end else begin
            len_d      = bus.load_len;
            word_cnt_d = '0;
            wr_addr_d  = '0;
            byte_cnt_d = '0;
            state_d    = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (hs) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    asm_d[7:0]   = bus.byte_in;
            2'd1:    asm_d[15:8]  = bus.byte_in;
            2'd2:    asm_d[23:16] = bus.byte_in;
            default: asm_d        = asm_q;
          endcase
          if (wr_en) begin
            // wr_addr wraps to 0 after a full-depth load; harmless since we leave LOAD now.
            wr_addr_d  = wr_addr_q + 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
            if ((word_cnt_q + 1'b1) == len_q) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state and counters, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      len_q         <= '0;
      word_cnt_q    <= '0;
      wr_addr_q     <= '0;
      byte_cnt_q    <= '0;
      load_error_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      wr_addr_q     <= wr_addr_d;
      byte_cnt_q    <= byte_cnt_d;
      load_error_q  <= load_error_d;
      fetch_valid_q <= fetch_valid_d;
    end
  end

  // Partial-word byte holding register; byte_cnt reset makes stale bytes irrelevant.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

  instr_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (wr_en),
    .waddr (wr_addr_q),
    .wdata (wr_word),
    .re    (rd_en),
    .raddr (bus.fetch_addr),
    .rdata (bus.fetch_instr)
  );

  assign bus.byte_ready  = (state_q == ST_LOAD);
  assign bus.load_busy   = (state_q == ST_LOAD);
  assign bus.load_done   = (state_q == ST_DONE);
  assign bus.load_error  = load_error_q;
  assign bus.fetch_valid = fetch_valid_q;

endmodule
